// File: rtl/alu_bcd_seq_if.sv
// Request/response bundle between the ALU issue stage and the nibble-serial
// ADC/SBC sequencer (master = issuer, slave = sequencer).
interface alu_bcd_seq_if;
   logic        START;
   logic [15:0] A;
   logic [15:0] B;
   logic        CI;
   logic        ADD;
   logic        BCD;
   logic        W16;
   logic        BUSY;
   logic        DONE;
   logic [15:0] RESULT;
   logic        CO;
   logic        VO;
   logic        ZO;
   logic        NO;

   modport master (output START, A, B, CI, ADD, BCD, W16,
                   input  BUSY, DONE, RESULT, CO, VO, ZO, NO);
   modport slave  (input  START, A, B, CI, ADD, BCD, W16,
                   output BUSY, DONE, RESULT, CO, VO, ZO, NO);
endinterface

// File: rtl/alu_bcd_seq.sv
// Nibble-serial ADC/SBC sequencer for the 65C816 ALU, one BCDAdder slice per clock.
// Optional ABORT input is enabled by defining ALU_BCD_SEQ_ABORT_EN.

module BCDAdder (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_ci,
   input  logic       i_add,
   input  logic       i_bcd,
   output logic [3:0] o_s,
   output logic       o_co,
   output logic       o_vo
);
   logic [3:0] w_b;
   logic [4:0] w_bin;
   logic [4:0] w_adj;

   always_comb begin
      w_b   = i_add ? i_b : ~i_b;
      w_bin = {1'b0, i_a} + {1'b0, w_b} + {4'd0, i_ci};
      // V comes from the unadjusted binary sum, also in decimal mode
      o_vo  = (i_a[3] == w_b[3]) && (w_bin[3] != i_a[3]);
      w_adj = w_bin;
      o_co  = w_bin[4];
      if (i_bcd) begin
         if (i_add) begin
            if (w_bin > 5'd9) begin
               w_adj = w_bin + 5'd6;
               o_co  = 1'b1;
            end
         end else if (!w_bin[4]) begin
            w_adj = w_bin - 5'd6;
         end
      end
      o_s = w_adj[3:0];
   end
endmodule

module alu_bcd_seq (
   input  logic          CLK,
   input  logic          RST,
`ifdef ALU_BCD_SEQ_ABORT_EN
   input  logic          ABORT,
`endif
   alu_bcd_seq_if.slave  bus
);
   localparam int NIB_W = 4;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [15:0]       r_a;
   logic [15:0]       r_b;
   logic              r_add;
   logic              r_bcd;
   logic              r_w16;
   logic              r_carry;
   logic [1:0]        r_idx;
   logic [15:0]       r_result;
   logic              r_co;
   logic              r_vo;
   logic              r_zo;
   logic              r_no;
   logic              r_busy;
   logic              r_done;
   logic [NIB_W-1:0]  w_a_nib;
   logic [NIB_W-1:0]  w_b_nib;
   logic [NIB_W-1:0]  w_s;
   logic              w_co;
   logic              w_vo;
   logic [15:0]       w_res_nxt;
   logic              w_zero;
   logic              w_last;
   logic              w_abort;

`ifdef ALU_BCD_SEQ_ABORT_EN
   logic [15:0]       r_shadow;
   assign w_abort = ABORT;
`else
   assign w_abort = 1'b0;
`endif

   BCDAdder u_bcd (
      .i_a   (w_a_nib),
      .i_b   (w_b_nib),
      .i_ci  (r_carry),
      .i_add (r_add),
      .i_bcd (r_bcd),
      .o_s   (w_s),
      .o_co  (w_co),
      .o_vo  (w_vo)
   );

   always_comb begin
      w_a_nib   = r_a[{r_idx, 2'b00} +: NIB_W];
      w_b_nib   = r_b[{r_idx, 2'b00} +: NIB_W];
      w_res_nxt = r_result;
      w_res_nxt[{r_idx, 2'b00} +: NIB_W] = w_s;
      w_zero    = r_w16 ? (w_res_nxt == 16'd0) : (w_res_nxt[7:0] == 8'd0);
      w_last    = (r_idx == (r_w16 ? 2'd3 : 2'd1));
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (bus.START) w_state_nxt = RUN;
         RUN:  if (w_abort || w_last) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_add    <= 1'b0;
         r_bcd    <= 1'b0;
         r_w16    <= 1'b0;
         r_carry  <= 1'b0;
         r_idx    <= '0;
         r_result <= '0;
         r_co     <= 1'b0;
         r_vo     <= 1'b0;
         r_zo     <= 1'b0;
         r_no     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.START) begin
                  r_a      <= bus.A;
                  r_b      <= bus.B;
                  r_add    <= bus.ADD;
                  r_bcd    <= bus.BCD;
                  r_w16    <= bus.W16;
                  r_carry  <= bus.CI;
                  r_idx    <= '0;
                  r_result <= '0;
                  r_busy   <= 1'b1;
               end
            end
            RUN: begin
               if (w_abort) begin
                  r_busy <= 1'b0;
`ifdef ALU_BCD_SEQ_ABORT_EN
                  r_result <= r_shadow;
`endif
               end else begin
                  r_result <= w_res_nxt;
                  r_carry  <= w_co;
                  r_idx    <= r_idx + 2'd1;
                  if (w_last) begin
                     r_co   <= w_co;
                     r_vo   <= w_vo;
                     r_no   <= w_s[3];
                     r_zo   <= w_zero;
                     r_done <= 1'b1;
                     r_busy <= 1'b0;
                  end
               end
            end
            default: r_busy <= 1'b0;
         endcase
      end
   end

`ifdef ALU_BCD_SEQ_ABORT_EN
   // Flags are untouched until the last slice, so only RESULT needs a copy
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                           r_shadow <= '0;
      else if (r_state == IDLE && bus.START) r_shadow <= r_result;
   end
`endif

   assign bus.BUSY   = r_busy;
   assign bus.DONE   = r_done;
   assign bus.RESULT = r_result;
   assign bus.CO     = r_co;
   assign bus.VO     = r_vo;
   assign bus.ZO     = r_zo;
   assign bus.NO     = r_no;
endmodule

// File: tb/tb_alu_bcd_seq.sv
// Randomized self-checking bench for alu_bcd_seq against a decimal/integer reference model.
`timescale 1ns/1ps
module tb_alu_bcd_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef ALU_BCD_SEQ_ABORT_EN
   logic abort = 1'b0;
`endif
   int checks = 0;
   int errors = 0;

   alu_bcd_seq_if bus();

   alu_bcd_seq dut (
      .CLK   (clk),
      .RST   (rst),
`ifdef ALU_BCD_SEQ_ABORT_EN
      .ABORT (abort),
`endif
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] res;
      logic        c, v, z, n;
   } exp_t;

   typedef struct {
      logic [15:0] a, b;
      logic        ci, add, bcd, w16;
      logic [15:0] res;
      logic        c, v, z, n, chkv;
   } vec_t;

   function automatic int dec(input logic [15:0] x, input int nd);
      int v;
      v = 0;
      for (int i = nd - 1; i >= 0; i--) v = v * 10 + int'((x >> (4 * i)) & 16'h000F);
      return v;
   endfunction

   function automatic logic [15:0] enc(input int val, input int nd);
      logic [15:0] r;
      int v;
      r = '0;
      v = val;
      for (int i = 0; i < nd; i++) begin
         r = r | (16'(v % 10) << (4 * i));
         v = v / 10;
      end
      return r;
   endfunction

   // Whole-operand arithmetic: decimal integers in BCD mode, signed/unsigned ints otherwise
   function automatic exp_t ref_op(input logic [15:0] a, b, input logic ci, add, bcd, w16);
      exp_t e;
      int nb, nd, mask, half, ai, bi, sa, sb, s, ss, m;
      nb   = w16 ? 16 : 8;
      nd   = nb / 4;
      mask = (1 << nb) - 1;
      half = 1 << (nb - 1);
      ai   = int'(a) & mask;
      bi   = int'(b) & mask;
      e.v  = 1'b0;
      if (bcd) begin
         m = w16 ? 10000 : 100;
         if (add) begin
            s = dec(a, nd) + dec(b, nd) + int'(ci);
            e.c = (s >= m);
            s = s % m;
         end else begin
            s = dec(a, nd) - dec(b, nd) - (ci ? 0 : 1);
            e.c = (s >= 0);
            if (s < 0) s = s + m;
         end
         e.res = enc(s, nd);
      end else begin
         sa = (ai >= half) ? ai - (1 << nb) : ai;
         sb = (bi >= half) ? bi - (1 << nb) : bi;
         if (add) begin
            s   = ai + bi + int'(ci);
            e.c = (s > mask);
            ss  = sa + sb + int'(ci);
         end else begin
            s   = ai - bi - (ci ? 0 : 1);
            e.c = (s >= 0);
            ss  = sa - sb - (ci ? 0 : 1);
         end
         e.v   = (ss > half - 1) || (ss < -half);
         e.res = 16'(s & mask);
      end
      e.z = (e.res == 16'd0);
      e.n = w16 ? e.res[15] : e.res[7];
      return e;
   endfunction

   function automatic logic [15:0] rand_bcd();
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r = r | (16'($urandom_range(0, 9)) << (4 * i));
      return r;
   endfunction

   // Issue one op, scramble the inputs after acceptance, return cycles to DONE (-1 on timeout)
   task automatic run_op(input logic [15:0] a, b, input logic ci, add, bcd, w16, output int lat);
      @(posedge clk); #1;
      bus.START = 1'b1; bus.A = a; bus.B = b; bus.CI = ci;
      bus.ADD = add; bus.BCD = bcd; bus.W16 = w16;
      @(posedge clk); #1;
      bus.START = 1'b0; bus.A = 16'($urandom); bus.B = 16'($urandom);
      bus.CI = 1'($urandom); bus.ADD = 1'($urandom); bus.BCD = 1'($urandom); bus.W16 = 1'($urandom);
      lat = -1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (bus.DONE) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.START = 1'b0; bus.A = 16'hFFFF; bus.B = 16'hFFFF;
      bus.CI = 1'b1; bus.ADD = 1'b1; bus.BCD = 1'b0; bus.W16 = 1'b1;
      #2;
      checks++;
      if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl: busy=%b done=%b, want 0 0", bus.BUSY, bus.DONE);
      end
      checks++;
      if (bus.RESULT !== 16'h0000) begin
         errors++; $display("FAIL reset_result: got %h want 0000", bus.RESULT);
      end
      checks++;
      if ({bus.CO, bus.VO, bus.ZO, bus.NO} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: cvzn=%b want 0000", {bus.CO, bus.VO, bus.ZO, bus.NO});
      end
      @(posedge clk); #3 rst = 1'b0;
   endtask

   task automatic test_directed();
      vec_t tbl[4];
      int lat;
      tbl[0] = '{16'h0045, 16'h0038, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0083, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{16'h0099, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{16'h1000, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0999, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{16'h007F, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].add, tbl[i].bcd, tbl[i].w16, lat);
         checks++;
         if (lat != (tbl[i].w16 ? 4 : 2)) begin
            errors++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, tbl[i].w16 ? 4 : 2);
         end
         checks++;
         if (bus.RESULT !== tbl[i].res || bus.BUSY !== 1'b0) begin
            errors++; $display("FAIL dir_result[%0d]: got %h busy=%b want %h busy=0", i, bus.RESULT, bus.BUSY, tbl[i].res);
         end
         checks++;
         if ({bus.CO, bus.ZO, bus.NO} !== {tbl[i].c, tbl[i].z, tbl[i].n}) begin
            errors++; $display("FAIL dir_flags[%0d]: czn=%b want %b", i, {bus.CO, bus.ZO, bus.NO}, {tbl[i].c, tbl[i].z, tbl[i].n});
         end
         if (tbl[i].chkv) begin
            checks++;
            if (bus.VO !== tbl[i].v) begin
               errors++; $display("FAIL dir_v[%0d]: got %b want %b", i, bus.VO, tbl[i].v);
            end
         end
         @(posedge clk); #1;
         checks++;
         if (bus.DONE !== 1'b0 || bus.RESULT !== tbl[i].res) begin
            errors++; $display("FAIL dir_hold[%0d]: done=%b result=%h want done=0 result=%h", i, bus.DONE, bus.RESULT, tbl[i].res);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] a, b;
      logic ci, add, bcd, w16;
      exp_t e;
      int lat;
      for (int i = 0; i < 40; i++) begin
         bcd = 1'($urandom); add = 1'($urandom); w16 = 1'($urandom); ci = 1'($urandom);
         a = bcd ? rand_bcd() : 16'($urandom);
         b = bcd ? rand_bcd() : 16'($urandom);
         e = ref_op(a, b, ci, add, bcd, w16);
         run_op(a, b, ci, add, bcd, w16, lat);
         checks++;
         if (lat != (w16 ? 4 : 2)) begin
            errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, w16 ? 4 : 2);
         end
         checks++;
         if ({bus.RESULT, bus.CO, bus.ZO, bus.NO} !== {e.res, e.c, e.z, e.n}) begin
            errors++;
            $display("FAIL rand_result[%0d] a=%h b=%h ci=%b add=%b bcd=%b w16=%b: got %h czn=%b want %h czn=%b",
                     i, a, b, ci, add, bcd, w16, bus.RESULT, {bus.CO, bus.ZO, bus.NO}, e.res, {e.c, e.z, e.n});
         end
         if (!bcd) begin
            checks++;
            if (bus.VO !== e.v) begin
               errors++; $display("FAIL rand_v[%0d] a=%h b=%h: got %b want %b", i, a, b, bus.VO, e.v);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      run_op(16'h007F, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, lat);
      // still in the DONE cycle: request the next op immediately
      bus.START = 1'b1; bus.A = 16'hFFFF; bus.B = 16'h0001;
      bus.CI = 1'b0; bus.ADD = 1'b1; bus.BCD = 1'b0; bus.W16 = 1'b1;
      @(posedge clk); #1;
      bus.START = 1'b0; bus.A = 16'($urandom); bus.B = 16'($urandom);
      checks++;
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b1) begin
         errors++; $display("FAIL b2b_accept: done=%b busy=%b want 0 1", bus.DONE, bus.BUSY);
      end
      checks++;
      if (bus.RESULT !== 16'h0000 || {bus.VO, bus.NO} !== 2'b11) begin
         errors++; $display("FAIL b2b_clear: result=%h vn=%b want 0000 11", bus.RESULT, {bus.VO, bus.NO});
      end
      lat = -1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (bus.DONE) begin lat = k; break; end
      end
      checks++;
      if (lat != 4) begin
         errors++; $display("FAIL b2b_latency: got %0d want 4", lat);
      end
      checks++;
      if ({bus.RESULT, bus.CO, bus.VO, bus.ZO, bus.NO} !== {16'h0000, 4'b1010}) begin
         errors++; $display("FAIL b2b_result: got %h cvzn=%b want 0000 1010", bus.RESULT, {bus.CO, bus.VO, bus.ZO, bus.NO});
      end
   endtask

   task automatic test_busy_start();
      exp_t e;
      int dcount;
      logic [15:0] seen;
      e = ref_op(16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
      @(posedge clk); #1;
      bus.START = 1'b1; bus.A = 16'h8000; bus.B = 16'h8000;
      bus.CI = 1'b0; bus.ADD = 1'b1; bus.BCD = 1'b0; bus.W16 = 1'b1;
      @(posedge clk); #1;
      bus.START = 1'b0;
      @(posedge clk); #1;
      bus.START = 1'b1; bus.A = 16'h1234; bus.B = 16'h0101; bus.W16 = 1'b0;
      @(posedge clk); #1;
      bus.START = 1'b0;
      dcount = 0;
      seen = 16'hDEAD;
      if (bus.DONE) begin dcount++; seen = bus.RESULT; end
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (bus.DONE) begin dcount++; seen = bus.RESULT; end
      end
      checks++;
      if (dcount != 1) begin
         errors++; $display("FAIL busy_done_count: got %0d want 1", dcount);
      end
      checks++;
      if (seen !== e.res || bus.RESULT !== e.res) begin
         errors++; $display("FAIL busy_result: at done %h now %h want %h", seen, bus.RESULT, e.res);
      end
      checks++;
      if ({bus.CO, bus.VO, bus.ZO, bus.NO} !== {e.c, e.v, e.z, e.n}) begin
         errors++; $display("FAIL busy_flags: cvzn=%b want %b", {bus.CO, bus.VO, bus.ZO, bus.NO}, {e.c, e.v, e.z, e.n});
      end
   endtask

   task automatic test_rst_mid();
      exp_t e;
      int lat;
      int dcount;
      @(posedge clk); #1;
      bus.START = 1'b1; bus.A = 16'h1234; bus.B = 16'h1111;
      bus.CI = 1'b0; bus.ADD = 1'b1; bus.BCD = 1'b0; bus.W16 = 1'b1;
      @(posedge clk); #1;
      bus.START = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.BUSY, bus.DONE, bus.RESULT, bus.CO, bus.VO, bus.ZO, bus.NO} !== 22'd0) begin
         errors++; $display("FAIL rst_mid_outputs: busy=%b done=%b result=%h cvzn=%b want all 0",
                            bus.BUSY, bus.DONE, bus.RESULT, {bus.CO, bus.VO, bus.ZO, bus.NO});
      end
      @(posedge clk); @(posedge clk); #4 rst = 1'b0;
      dcount = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (bus.DONE || bus.BUSY) dcount++;
      end
      checks++;
      if (dcount != 0) begin
         errors++; $display("FAIL rst_mid_resume: %0d cycles with busy/done, want 0", dcount);
      end
      e = ref_op(16'h0456, 16'h0789, 1'b1, 1'b1, 1'b1, 1'b1);
      run_op(16'h0456, 16'h0789, 1'b1, 1'b1, 1'b1, 1'b1, lat);
      checks++;
      if (lat != 4 || bus.RESULT !== e.res || bus.CO !== e.c) begin
         errors++; $display("FAIL rst_fresh_op: lat=%0d result=%h c=%b want 4 %h %b", lat, bus.RESULT, bus.CO, e.res, e.c);
      end
   endtask

`ifdef ALU_BCD_SEQ_ABORT_EN
   task automatic test_abort();
      exp_t e;
      int lat;
      int dcount;
      e = ref_op(16'h0012, 16'h0034, 1'b0, 1'b1, 1'b1, 1'b0);
      run_op(16'h0012, 16'h0034, 1'b0, 1'b1, 1'b1, 1'b0, lat);
      @(posedge clk); #1;
      bus.START = 1'b1; bus.A = 16'h1111; bus.B = 16'h2222; bus.W16 = 1'b1; bus.BCD = 1'b0;
      @(posedge clk); #1;
      bus.START = 1'b0;
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checks++;
      if (bus.BUSY !== 1'b0 || bus.RESULT !== e.res || {bus.CO, bus.ZO, bus.NO} !== {e.c, e.z, e.n}) begin
         errors++; $display("FAIL abort_restore: busy=%b result=%h czn=%b want 0 %h %b",
                            bus.BUSY, bus.RESULT, {bus.CO, bus.ZO, bus.NO}, e.res, {e.c, e.z, e.n});
      end
      dcount = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (bus.DONE) dcount++;
      end
      checks++;
      if (dcount != 0) begin
         errors++; $display("FAIL abort_no_done: got %0d done pulses want 0", dcount);
      end
      // ABORT coinciding with START in IDLE must not block acceptance
      e = ref_op(16'h0100, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1);
      @(posedge clk); #1;
      bus.START = 1'b1; abort = 1'b1; bus.A = 16'h0100; bus.B = 16'h0001;
      bus.CI = 1'b1; bus.ADD = 1'b1; bus.BCD = 1'b0; bus.W16 = 1'b1;
      @(posedge clk); #1;
      bus.START = 1'b0; abort = 1'b0;
      lat = -1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (bus.DONE) begin lat = k; break; end
      end
      checks++;
      if (lat != 4 || bus.RESULT !== e.res) begin
         errors++; $display("FAIL abort_idle_start: lat=%0d result=%h want 4 %h", lat, bus.RESULT, e.res);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_busy_start();
      test_rst_mid();
`ifdef ALU_BCD_SEQ_ABORT_EN
      test_abort();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_bcd_seq.md
Name: alu_bcd_seq

Overview:
- Nibble-serial ADC/SBC sequencer for the 65C816 ALU path.
- Latches 8- or 16-bit operands and drives one BCDAdder instance, one 4-bit slice per clock, LSB nibble first.
- Chains the slice carry and assembles the result plus N/V/Z/C flags for the status-register update stage.
- Sits directly upstream of BCDAdder (feeds it) and upstream of the P-register writeback.

Parameters:
- NIB_W, 4, slice width fed to BCDAdder; fixed, not overridable.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled only while idle.
- A  in  16  operand A (accumulator).
- B  in  16  operand B (memory operand).
- CI  in  1  carry in (SBC: 1 = no borrow).
- ADD  in  1  1 = ADC, 0 = SBC.
- BCD  in  1  decimal mode (P.D).
- W16  in  1  1 = 16-bit (M=0), 0 = 8-bit.
- BUSY  out  1  sequence in progress.
- DONE  out  1  one-cycle pulse; RESULT and flags valid.
- RESULT  out  16  sum/difference.
- CO  out  1  carry out.
- VO  out  1  overflow.
- ZO  out  1  result zero.
- NO  out  1  result sign.

Behaviour:
- One clock; reset is asynchronous and active-high (CLK, RST).
- RST: state IDLE; BUSY=0, DONE=0, RESULT=0, CO=0, VO=0, ZO=0, NO=0; internal carry, index and operand latches = 0. RST asserted mid-RUN aborts immediately, no DONE is produced, and the sequence does not resume after release.
- States: IDLE, RUN.
  - IDLE & START at edge 0: latch A, B, ADD, BCD, W16; carry <= CI; idx <= 0; RESULT <= 0; -> RUN; BUSY=1 from edge 0.
  - RUN at each edge k=1..N (N = 2 if W16=0, else 4):
    - Drive BCDAdder with A=Alat[4idx+3:4idx], B=Blat[4idx+3:4idx], CI=carry, ADD/BCD latched.
    - RESULT nibble idx <= S; carry <= CO; idx <= idx+1.
  - At edge N: CO <= slice CO; VO <= slice VO; NO <= S[3]; ZO <= (assembled 8/16-bit result == 0); DONE <= 1; BUSY <= 0; -> IDLE.
- DONE is high exactly one cycle (edges N..N+1).
- Latency START->DONE: 8-bit = 2 cycles, 16-bit = 4 cycles.
- RESULT and flags hold until the next accepted START; at acceptance RESULT clears to 0 while flags hold until edge N.
- 8-bit mode: RESULT[15:8] = 0; ZO/NO evaluated on [7:0] only.
- START while BUSY: ignored; operand inputs are don't-care outside the sampling edge.
- START in the DONE cycle (state already IDLE): accepted; DONE drops next cycle while BUSY rises.
- VO is taken from the top slice only (binary-style overflow in BCD mode, matching 65C816 decimal V).
- Combinational path limited to one BCDAdder; all outputs registered.

Optional Feature:
- Macro ALU_BCD_SEQ_ABORT_EN.
- Defined: adds input port ABORT (1 bit), placed after RST. ABORT=1 sampled in RUN forces -> IDLE, BUSY=0, no DONE pulse, and RESULT/flags keep their pre-START values (shadow copies are restored). ABORT is ignored in IDLE; if ABORT and START occur together in IDLE, START wins.
- Undefined: no ABORT port; every accepted START completes.

Test Plan:
- 8-bit BCD ADC: A=0x0045, B=0x0038, CI=0 -> DONE 2 cycles after START, RESULT=0x0083, C=0, Z=0, N=1.
- 8-bit BCD ADC: A=0x0099, B=0x0001, CI=0 -> RESULT=0x0000, C=1, Z=1, N=0.
- 16-bit BCD SBC: A=0x1000, B=0x0001, CI=1 -> DONE after 4 cycles, RESULT=0x0999, C=1, Z=0.
- 8-bit binary ADC: A=0x007F, B=0x0001, CI=0 -> RESULT=0x0080, V=1, N=1, C=0. Back-to-back: 16-bit binary 0xFFFF+0x0001 with START in the DONE cycle -> RESULT=0x0000, C=1, Z=1 after 4 further cycles.
- START pulsed while BUSY -> ignored; DONE count = 1 and RESULT unchanged from the first operation.
- RST asserted at edge 2 of a 16-bit op -> all outputs 0 asynchronously, no DONE; a fresh START after release completes normally. With ALU_BCD_SEQ_ABORT_EN defined: ABORT at edge 2 -> no DONE, RESULT equal to prior value.
